// File: rtl/vcmux_rr_pkg.sv
// Shared defaults, enable constants and a one-hot to index helper for the VC output mux.
package vcmux_rr_pkg;

  localparam int DATAW_DEF = 64;
  localparam int VCHW_DEF  = 2;
  localparam int PORTW_DEF = 3;

  localparam int ENABLE  = 1;
  localparam int DISABLE = 0;

  // Widest one-hot vector the helper accepts; callers zero-extend.
  localparam int OH_MAXW = 32;

  // OR-ing the indices of set bits gives the index for a one-hot input and 0 for all-zero.
  function automatic int unsigned oh2idx(input logic [OH_MAXW-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < OH_MAXW; i++) begin
      if (oh[i]) idx = idx | int'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/vcmux_rr_arbiter.sv
// Rotating-priority arbiter: a non-zero hold_vec wins outright, otherwise the
// lowest requester at or above ptr wins, wrapping to the lowest requester overall.
module rr_arbiter
  import vcmux_rr_pkg::*;
#(
  parameter int NVC = 4,
  parameter int IDW = 2
) (
  input  logic [NVC-1:0] req,
  input  logic [IDW-1:0] ptr,
  input  logic [NVC-1:0] hold_vec,
  output logic [NVC-1:0] gnt
);

  logic [NVC-1:0] lo_mask;
  logic [NVC-1:0] req_hi;
  logic [NVC-1:0] pick_src;
  logic [NVC-1:0] rr_gnt;

  assign lo_mask  = (NVC'(1) << ptr) - NVC'(1);
  assign req_hi   = req & ~lo_mask;
  assign pick_src = (|req_hi) ? req_hi : req;
  // Isolate the lowest set bit of the chosen search window.
  assign rr_gnt   = pick_src & (~pick_src + NVC'(1));
  assign gnt      = (|hold_vec) ? hold_vec : rr_gnt;

endmodule

// File: rtl/vcmux_rr.sv
// N-VC output mux with round-robin grant, packet or request locking and a max-hold guard.
// Grant is same-cycle combinational; data follows the registered lock one cycle later; out_stall freezes lock state.
module vcmux_rr
  import vcmux_rr_pkg::*;
#(
  parameter int NVC      = 4,
  parameter int DATAW    = DATAW_DEF,
  parameter int VCHW     = VCHW_DEF,
  parameter int PORTW    = PORTW_DEF,
  parameter int PKT_LOCK = ENABLE,
  parameter int MAX_HOLD = 16,
  localparam int IDW     = (NVC > 1) ? $clog2(NVC) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NVC-1:0]         in_valid,
  input  logic [NVC-1:0]         in_req,
  input  logic [NVC-1:0]         in_tail,
  input  logic [NVC*DATAW-1:0]   in_data,
  input  logic [NVC*VCHW-1:0]    in_vch,
  input  logic [NVC*PORTW-1:0]   in_port,
  input  logic                   out_stall,
  output logic                   ovalid,
  output logic [DATAW-1:0]       odata,
  output logic [VCHW-1:0]        ovch,
  output logic                   req,
  output logic [PORTW-1:0]       port,
  output logic [NVC-1:0]         vcsel,
  output logic [IDW-1:0]         gnt_id
);

  localparam int HCW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HCW-1:0] HOLD_SAT  = HCW'(MAX_HOLD);
  localparam logic [HCW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HCW'(MAX_HOLD - 1) : '0;

  logic           lock_vld;
  logic [IDW-1:0] lock_id;
  logic [IDW-1:0] rr_ptr;
  logic [HCW-1:0] hold_cnt;

  logic [NVC-1:0] lock_oh;
  logic [NVC-1:0] hold_vec;
  logic [NVC-1:0] grt;
  logic [IDW-1:0] grt_id;
  logic [IDW-1:0] next_ptr;
  logic           ovalid_int;
  logic           acc;
  logic           rel;
  logic           hold;

  logic [DATAW-1:0] data_sel;
  logic [VCHW-1:0]  vch_sel;
  logic [PORTW-1:0] port_sel;

  assign lock_oh    = NVC'(1) << lock_id;
  assign ovalid_int = lock_vld & |(in_valid & lock_oh);
  assign acc        = ovalid_int & ~out_stall;

  generate
    if (PKT_LOCK != DISABLE) begin : g_pkt_lock
      // Only an accepted tail ends the packet; dropping the request mid-packet does not.
      assign rel = acc & |(in_tail & lock_oh);
    end else begin : g_req_lock
      logic req_own;
      logic req_other;
      assign req_own   = |(in_req & lock_oh);
      assign req_other = |(in_req & ~lock_oh);
      assign rel = ~req_own |
                   ((MAX_HOLD != 0) & (hold_cnt == HOLD_LAST) & acc & req_other);
    end
  endgenerate

  assign hold     = lock_vld & ~rel;
  assign hold_vec = hold ? lock_oh : '0;

  rr_arbiter #(
    .NVC (NVC),
    .IDW (IDW)
  ) u_arb (
    .req      (in_req),
    .ptr      (rr_ptr),
    .hold_vec (hold_vec),
    .gnt      (grt)
  );

  assign grt_id   = IDW'(oh2idx(OH_MAXW'(grt)));
  assign next_ptr = (grt_id == IDW'(NVC - 1)) ? '0 : grt_id + 1'b1;

  always_comb begin
    data_sel = '0;
    vch_sel  = '0;
    port_sel = '0;
    for (int i = 0; i < NVC; i++) begin
      if (lock_vld && lock_oh[i]) begin
        data_sel = in_data[i*DATAW +: DATAW];
        vch_sel  = in_vch[i*VCHW +: VCHW];
      end
      if (grt[i]) port_sel = in_port[i*PORTW +: PORTW];
    end
  end

  // Registered-state outputs clear through the async reset; combinational ones are gated here.
  assign ovalid = ovalid_int;
  assign odata  = data_sel;
  assign ovch   = vch_sel;
  assign gnt_id = lock_id;
  assign req    = ~rst & |in_req;
  assign vcsel  = rst ? '0 : grt;
  assign port   = rst ? '0 : port_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_vld <= 1'b0;
      lock_id  <= '0;
      rr_ptr   <= '0;
      hold_cnt <= '0;
    end else begin
      lock_vld <= |grt;
      lock_id  <= grt_id;
      if (hold) begin
        if (acc && hold_cnt != HOLD_SAT) hold_cnt <= hold_cnt + 1'b1;
      end else begin
        hold_cnt <= '0;
        if (|grt) rr_ptr <= next_ptr;
      end
    end
  end

endmodule

// File: tb/tb_vcmux_rr.sv
// Random-stimulus bench for vcmux_rr: a packet-lock instance and a request-lock
// instance (MAX_HOLD=4) share inputs and are each compared against a rule-level model.
module tb_vcmux_rr;

  localparam int NVC   = 4;
  localparam int DATAW = 64;
  localparam int VCHW  = 2;
  localparam int PORTW = 3;
  localparam int NCYC  = 1500;
  localparam int RST_CYC = 700;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NVC-1:0]       in_valid, in_req, in_tail;
  logic [NVC*DATAW-1:0] in_data;
  logic [NVC*VCHW-1:0]  in_vch;
  logic [NVC*PORTW-1:0] in_port;
  logic                 out_stall;

  logic             a_ovalid, b_ovalid;
  logic [DATAW-1:0] a_odata, b_odata;
  logic [VCHW-1:0]  a_ovch, b_ovch;
  logic             a_req, b_req;
  logic [PORTW-1:0] a_port, b_port;
  logic [NVC-1:0]   a_vcsel, b_vcsel;
  logic [1:0]       a_gnt_id, b_gnt_id;

  vcmux_rr #(.NVC(NVC), .DATAW(DATAW), .VCHW(VCHW), .PORTW(PORTW),
             .PKT_LOCK(1), .MAX_HOLD(16)) u_lock (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_req(in_req), .in_tail(in_tail),
    .in_data(in_data), .in_vch(in_vch), .in_port(in_port), .out_stall(out_stall),
    .ovalid(a_ovalid), .odata(a_odata), .ovch(a_ovch), .req(a_req), .port(a_port),
    .vcsel(a_vcsel), .gnt_id(a_gnt_id));

  vcmux_rr #(.NVC(NVC), .DATAW(DATAW), .VCHW(VCHW), .PORTW(PORTW),
             .PKT_LOCK(0), .MAX_HOLD(4)) u_beat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_req(in_req), .in_tail(in_tail),
    .in_data(in_data), .in_vch(in_vch), .in_port(in_port), .out_stall(out_stall),
    .ovalid(b_ovalid), .odata(b_odata), .ovch(b_ovch), .req(b_req), .port(b_port),
    .vcsel(b_vcsel), .gnt_id(b_gnt_id));

  // Stimulus copies in unpacked form for the model.
  logic [DATAW-1:0] d  [NVC];
  logic [VCHW-1:0]  vc [NVC];
  logic [PORTW-1:0] pt [NVC];

  // Model state per instance: owner (-1 = none), next priority VC, accepted beats.
  int pl [2] = '{1, 0};
  int mh [2] = '{16, 4};
  int owner [2], nextp [2], beats [2];
  int nx_owner [2], nx_nextp [2], nx_beats [2];

  int total = 0;
  int bad   = 0;
  int mode;
  int solo;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      owner[k] = -1;
      nextp[k] = 0;
      beats[k] = 0;
    end
  endtask

  function automatic bit coin(input int pct);
    return $urandom_range(0, 99) < pct;
  endfunction

  task automatic drive_inputs();
    int p_stall, p_tail;
    p_stall = (mode == 3) ? 70 : 20;
    p_tail  = (mode == 2) ? 50 : 25;
    for (int i = 0; i < NVC; i++) begin
      case (mode)
        1:       in_req[i] = (i == solo) && coin(85);
        2:       in_req[i] = 1'b1;
        default: if (coin(15)) in_req[i] = ~in_req[i];
      endcase
      in_valid[i] = coin(85);
      in_tail[i]  = coin(p_tail);
      d[i]  = {$urandom, $urandom};
      vc[i] = VCHW'($urandom);
      pt[i] = PORTW'($urandom);
      in_data[i*DATAW +: DATAW] = d[i];
      in_vch[i*VCHW +: VCHW]    = vc[i];
      in_port[i*PORTW +: PORTW] = pt[i];
    end
    out_stall = coin(p_stall);
  endtask

  task automatic model_cycle(input int k, input int cyc, input logic ov,
                             input logic [DATAW-1:0] od, input logic [VCHW-1:0] oc,
                             input logic rq, input logic [PORTW-1:0] po,
                             input logic [NVC-1:0] vs, input logic [1:0] gi);
    string nm;
    int o, win, c;
    bit e_ov, accepted, released, keep, others;
    logic [NVC-1:0] e_vs;
    nm = (k == 0) ? "pkt" : "beat";
    o  = owner[k];
    e_ov = (o >= 0) && in_valid[o];
    accepted = e_ov && !out_stall;
    released = 1'b0;
    if (o >= 0) begin
      others = (in_req & ~(NVC'(1) << o)) != '0;
      if (pl[k] != 0) released = accepted && in_tail[o];
      else released = !in_req[o] ||
                      (mh[k] > 0 && beats[k] == mh[k] - 1 && accepted && others);
    end
    keep = (o >= 0) && !released;
    win = -1;
    if (keep) win = o;
    else begin
      for (int j = 0; j < NVC; j++) begin
        c = (nextp[k] + j) % NVC;
        if (win < 0 && in_req[c]) win = c;
      end
    end
    e_vs = (win < 0) ? '0 : NVC'(1) << win;

    chk($sformatf("c%0d %s ovalid", cyc, nm), 64'(ov), 64'(e_ov));
    chk($sformatf("c%0d %s odata", cyc, nm), 64'(od), (o >= 0) ? 64'(d[o]) : 64'd0);
    chk($sformatf("c%0d %s ovch", cyc, nm), 64'(oc), (o >= 0) ? 64'(vc[o]) : 64'd0);
    chk($sformatf("c%0d %s req", cyc, nm), 64'(rq), 64'(|in_req));
    chk($sformatf("c%0d %s vcsel", cyc, nm), 64'(vs), 64'(e_vs));
    chk($sformatf("c%0d %s port", cyc, nm), 64'(po), (win >= 0) ? 64'(pt[win]) : 64'd0);
    chk($sformatf("c%0d %s gnt_id", cyc, nm), 64'(gi), (o >= 0) ? 64'(o) : 64'd0);

    nx_owner[k] = win;
    nx_nextp[k] = nextp[k];
    if (keep) begin
      nx_beats[k] = beats[k] + ((accepted && beats[k] < mh[k]) ? 1 : 0);
    end else begin
      nx_beats[k] = 0;
      if (win >= 0) nx_nextp[k] = (win + 1) % NVC;
    end
  endtask

  task automatic chk_all_zero(input string when);
    chk({when, " pkt ovalid"}, 64'(a_ovalid), 64'd0);
    chk({when, " pkt odata"},  64'(a_odata),  64'd0);
    chk({when, " pkt ovch"},   64'(a_ovch),   64'd0);
    chk({when, " pkt req"},    64'(a_req),    64'd0);
    chk({when, " pkt port"},   64'(a_port),   64'd0);
    chk({when, " pkt vcsel"},  64'(a_vcsel),  64'd0);
    chk({when, " pkt gnt_id"}, 64'(a_gnt_id), 64'd0);
    chk({when, " beat ovalid"}, 64'(b_ovalid), 64'd0);
    chk({when, " beat odata"},  64'(b_odata),  64'd0);
    chk({when, " beat ovch"},   64'(b_ovch),   64'd0);
    chk({when, " beat req"},    64'(b_req),    64'd0);
    chk({when, " beat port"},   64'(b_port),   64'd0);
    chk({when, " beat vcsel"},  64'(b_vcsel),  64'd0);
    chk({when, " beat gnt_id"}, 64'(b_gnt_id), 64'd0);
  endtask

  initial begin
    rst       = 1'b1;
    mode      = 0;
    solo      = 0;
    in_req    = '1;
    in_valid  = '1;
    in_tail   = '0;
    in_data   = '1;
    in_vch    = '1;
    in_port   = '1;
    out_stall = 1'b0;
    for (int i = 0; i < NVC; i++) begin
      d[i] = '1; vc[i] = '1; pt[i] = '1;
    end
    model_reset();
    #2;
    chk_all_zero("reset");
    @(posedge clk);

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      rst = 1'b0;
      if (cyc % 50 == 0) begin
        mode = $urandom_range(0, 3);
        solo = $urandom_range(0, NVC - 1);
      end
      drive_inputs();
      #1;
      model_cycle(0, cyc, a_ovalid, a_odata, a_ovch, a_req, a_port, a_vcsel, a_gnt_id);
      model_cycle(1, cyc, b_ovalid, b_odata, b_ovch, b_req, b_port, b_vcsel, b_gnt_id);
      if (cyc == RST_CYC) begin
        // Mid-run reset with requests still asserted: outputs must clear at once.
        in_req   = '1;
        in_valid = '1;
        rst      = 1'b1;
        #1;
        chk_all_zero("midreset");
        model_reset();
        @(posedge clk);
      end else begin
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
          owner[k] = nx_owner[k];
          nextp[k] = nx_nextp[k];
          beats[k] = nx_beats[k];
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vcmux_rr.md
Name: vcmux_rr

Overview:
- Parametrised N-channel virtual-channel output multiplexer with round-robin arbitration. It is the next generation of the router's single-VC output mux.
- Sits between the per-VC buffers (vc stage) and the crossbar/output port. Selects one VC per cycle and forwards its flit, VC id and destination port.
- Adds three capabilities: fair rotating priority, packet-level locking (head to tail), and a max-hold starvation guard.
- Adds downstream stall backpressure.

Parameters:
- NVC, 4, number of virtual channels (>=1).
- DATAW, 64, flit data width in bits.
- VCHW, 2, VC id field width.
- PORTW, 3, destination port field width.
- PKT_LOCK, 1. 1 = hold grant from first accepted beat until tail beat is accepted. 0 = hold while req asserted.
- MAX_HOLD, 16. PKT_LOCK=0 only: force release after this many accepted beats if another VC requests. 0 = unlimited.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  NVC  per-VC flit valid.
- in_req  in  NVC  per-VC transmit request.
- in_tail  in  NVC  per-VC tail-flit flag.
- in_data  in  NVC*DATAW  packed flit data, VC i at [i*DATAW +: DATAW].
- in_vch  in  NVC*VCHW  packed VC id fields.
- in_port  in  NVC*PORTW  packed destination ports.
- out_stall  in  1  downstream cannot accept this cycle.
- ovalid  out  1  forwarded flit valid.
- odata  out  DATAW  forwarded flit.
- ovch  out  VCHW  forwarded VC id.
- req  out  1  OR of in_req.
- port  out  PORTW  destination port of current grant.
- vcsel  out  NVC  one-hot grant (combinational, same cycle).
- gnt_id  out  clog2(NVC) (min 1)  encoded lock owner.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- State registers: lock_vld, lock_id, rr_ptr, hold_cnt (width clog2(MAX_HOLD+1)).
  - Reset value of all state is 0.
  - All outputs are 0 while rst is asserted; this applies immediately (asynchronously) on a mid-packet reset.
- Accepted beat: acc = ovalid & ~out_stall.
- Release (combinational):
  - PKT_LOCK=1: rel = acc & in_tail[lock_id]. Deassertion of in_req[lock_id] mid-packet does NOT release; ovalid then follows in_valid.
  - PKT_LOCK=0: rel = ~in_req[lock_id] | (MAX_HOLD!=0 & hold_cnt==MAX_HOLD-1 & acc & |(in_req & ~onehot(lock_id))).
- hold = lock_vld & ~rel.
- Grant (combinational):
  - If hold, grt = onehot(lock_id).
  - Otherwise, grt is the first set in_req bit searching from rr_ptr upward, modulo NVC. If no request, grt = 0.
  - vcsel = grt.
- Register update each clk:
  - lock_vld <= |grt.
  - lock_id <= index(grt).
  - On a new grant (not hold): rr_ptr <= (index+1) mod NVC and hold_cnt <= 0.
  - While holding: hold_cnt increments on acc, saturating at MAX_HOLD.
- Same-cycle release and requests: a new winner is chosen in the release cycle with zero bubble. The releasing VC may re-win only if it is the sole requester.
- Datapath: odata, ovch and ovalid are selected by the registered lock, so data appears one cycle after the first grant.
  - ovalid = lock_vld & in_valid[lock_id].
  - odata = lock_vld ? in_data[lock_id] : 0.
  - ovch = lock_vld ? in_vch[lock_id] : 0.
  - port = |grt ? in_port[index(grt)] : 0.
  - gnt_id = lock_id.
- out_stall: no change to lock or counter. Outputs reflect the current inputs; the upstream VC must hold its flit.
- NVC=1: the arbiter degenerates to a pass-through grant; rr_ptr is constant 0.

Decomposition:
- Shared package: DATAW/VCHW/PORTW defaults, the Enable/Disable constants, and a onehot-to-index function.
- One sub-module, rr_arbiter: NVC-wide rotating-priority arbiter with req, ptr and hold_vec inputs and a one-hot grant output. The lock, counter and mux logic stay in vcmux_rr.

Test Plan:
1. Reset then idle: rst=1 mid-packet, then in_req=0 -> all outputs 0. After release, vcsel=0 and ovalid=0.
2. Round-robin, PKT_LOCK=0, NVC=4: in_req=4'b1111 held, each VC drops req after 1 beat -> grant order 0,1,2,3,0. odata matches each VC's data one cycle after its vcsel.
3. Packet lock, PKT_LOCK=1: VC2 sends a 3-flit packet (tail on beat 3) while VC1 requests; VC2 drops req at beat 2 -> lock stays on VC2 through the tail. vcsel switches to VC1 in the tail-acceptance cycle.
4. Starvation guard, PKT_LOCK=0, MAX_HOLD=4: VC0 requests continuously and VC3 requests from cycle 2 -> VC0 is released after 4 accepted beats. VC3 is granted the same cycle; ovch=VC3's id next cycle.
5. Stall: out_stall=1 for 5 cycles mid-packet -> lock_id, hold_cnt and grant unchanged; no tail release. Progress resumes when stall drops.
6. Simultaneous release and sole requester: VC1 releases on tail while only VC1 requests -> VC1 is re-granted with no idle cycle, and rr_ptr=2.
